// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 baseline-ISA decode/control stage.
//   - ALU opcode constants, writeback-source encodings
//   - FSM state encoding, execution-path and immediate-mode encodings
//   - instruction op/ext field constants
//   - decode_instr(): maps op/ext fields to a control bundle
// Configuration macro: IMM_SHIFT_EN (when defined, LSHI is decoded as SLL with an immediate
// shift amount; otherwise LSHI is an unsupported encoding).
package cr16_pkg;

    // ALU opcodes
    localparam logic [3:0] AluAnd = 4'd0;
    localparam logic [3:0] AluOr  = 4'd1;
    localparam logic [3:0] AluXor = 4'd2;
    localparam logic [3:0] AluAdd = 4'd3;
    localparam logic [3:0] AluSub = 4'd4;
    localparam logic [3:0] AluNot = 4'd5;
    localparam logic [3:0] AluSll = 4'd6;
    localparam logic [3:0] AluSrl = 4'd7;

    // Writeback source select
    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbImm = 2'd2;
    localparam logic [1:0] WbRfb = 2'd3;

    // Primary opcode field instr[15:12]
    localparam logic [3:0] OpRtype   = 4'b0000;
    localparam logic [3:0] OpAndi    = 4'b0001;
    localparam logic [3:0] OpOri     = 4'b0010;
    localparam logic [3:0] OpXori    = 4'b0011;
    localparam logic [3:0] OpSpecial = 4'b0100;
    localparam logic [3:0] OpAddi    = 4'b0101;
    localparam logic [3:0] OpShift   = 4'b1000;
    localparam logic [3:0] OpSubi    = 4'b1001;
    localparam logic [3:0] OpCmpi    = 4'b1011;
    localparam logic [3:0] OpBcond   = 4'b1100;
    localparam logic [3:0] OpMovi    = 4'b1101;
    localparam logic [3:0] OpLui     = 4'b1111;

    // Extended opcode field instr[7:4]
    localparam logic [3:0] ExtAnd  = 4'b0001;
    localparam logic [3:0] ExtOr   = 4'b0010;
    localparam logic [3:0] ExtXor  = 4'b0011;
    localparam logic [3:0] ExtAdd  = 4'b0101;
    localparam logic [3:0] ExtSub  = 4'b1001;
    localparam logic [3:0] ExtCmp  = 4'b1011;
    localparam logic [3:0] ExtMov  = 4'b1101;
    localparam logic [3:0] ExtLsh  = 4'b0100;
    localparam logic [3:0] ExtLoad = 4'b0000;
    localparam logic [3:0] ExtStor = 4'b0100;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [1:0] {
        PathExec,
        PathMem,
        PathWb
    } path_e;

    typedef enum logic [1:0] {
        ImmZero,
        ImmSign,
        ImmUpper,
        ImmShift
    } imm_mode_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic       set_znl;
        logic       use_imm;
        imm_mode_e  imm_mode;
        logic [1:0] wb_sel;
        path_e      path;
        logic       mem_we;
    } dec_t;

    function automatic dec_t decode_instr(input logic [3:0] op, input logic [3:0] ext);
        dec_t d;
        d          = '0;
        d.imm_mode = ImmZero;
        d.path     = PathExec;
        d.wb_sel   = WbAlu;
        case (op)
            OpRtype: begin
                d.valid = 1'b1;
                case (ext)
                    ExtAnd: d.alu_op = AluAnd;
                    ExtOr:  d.alu_op = AluOr;
                    ExtXor: d.alu_op = AluXor;
                    ExtAdd: d.alu_op = AluAdd;
                    ExtSub: d.alu_op = AluSub;
                    ExtCmp: begin
                        d.alu_op  = AluSub;
                        d.set_znl = 1'b1;
                    end
                    ExtMov: begin
                        d.path   = PathWb;
                        d.wb_sel = WbRfb;
                    end
                    default: d.valid = 1'b0;
                endcase
            end
            OpAndi, OpOri, OpXori: begin
                d.valid   = 1'b1;
                d.use_imm = 1'b1;
                d.alu_op  = (op == OpAndi) ? AluAnd : (op == OpOri) ? AluOr : AluXor;
            end
            OpAddi, OpSubi, OpCmpi: begin
                d.valid    = 1'b1;
                d.use_imm  = 1'b1;
                d.imm_mode = ImmSign;
                d.alu_op   = (op == OpAddi) ? AluAdd : AluSub;
                d.set_znl  = (op == OpCmpi);
            end
            OpMovi: begin
                d.valid   = 1'b1;
                d.use_imm = 1'b1;
                d.path    = PathWb;
                d.wb_sel  = WbImm;
            end
            OpLui: begin
                d.valid    = 1'b1;
                d.use_imm  = 1'b1;
                d.imm_mode = ImmUpper;
                d.path     = PathWb;
                d.wb_sel   = WbImm;
            end
            OpShift: begin
                if (ext == ExtLsh) begin
                    // Signed Rsrc amount; the ALU shifts right on negative values.
                    d.valid  = 1'b1;
                    d.alu_op = AluSll;
                end
`ifdef IMM_SHIFT_EN
                else if (ext[3:1] == 3'b000) begin
                    d.valid    = 1'b1;
                    d.alu_op   = AluSll;
                    d.use_imm  = 1'b1;
                    d.imm_mode = ImmShift;
                end
`endif
            end
            OpSpecial: begin
                if (ext == ExtLoad) begin
                    d.valid  = 1'b1;
                    d.path   = PathMem;
                    d.wb_sel = WbMem;
                end else if (ext == ExtStor) begin
                    d.valid  = 1'b1;
                    d.path   = PathMem;
                    d.mem_we = 1'b1;
                end
            end
            default: d.valid = 1'b0; // Bcond and unlisted opcodes
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extender for the decode path.
// Ports:
//   imm8     in   8      raw immediate field instr[7:0]
//   mode     in   2      ImmZero / ImmSign / ImmUpper / ImmShift
//   imm_out  out  WIDTH  extended immediate
// ImmShift: imm8[4] is the direction bit, imm8[3:0] the magnitude; result is +/-amt.
module imm_ext
    import cr16_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0]       imm8,
    input  imm_mode_e        mode,
    output logic [WIDTH-1:0] imm_out
);

    logic [WIDTH-1:0] amt;

    assign amt = {{(WIDTH-4){1'b0}}, imm8[3:0]};

    always_comb begin
        imm_out = '0;
        unique case (mode)
            ImmZero:  imm_out = {{(WIDTH-8){1'b0}}, imm8};
            ImmSign:  imm_out = {{(WIDTH-8){imm8[7]}}, imm8};
            ImmUpper: imm_out = {imm8, {(WIDTH-8){1'b0}}};
            ImmShift: imm_out = imm8[4] ? (~amt + 1'b1) : amt;
            default:  imm_out = '0;
        endcase
    end

endmodule

// File: rtl/instr_ctrl_fsm.sv
// Multi-cycle decode/control stage upstream of the ALU and register file.
// Sequences IDLE -> DECODE -> {EXEC | MEM | WB | IDLE}, EXEC -> WB/IDLE, MEM -> WB/IDLE,
// WB -> IDLE. Decoded operand/writeback fields are registered on leaving DECODE and held
// through WB; strobes (alu_op, set_znl, rf_wr_en, mem_req, ctrl_unsup) are decoded from state.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr, instr_valid         instruction handshake in; instr_ready out (IDLE only)
//   alu_op, set_znl            ALU controls, valid in EXEC only
//   rd_addr_a, rd_addr_b       RF read addresses (Rdest, Rsrc)
//   use_imm, imm_out           ALU in2 select and extended immediate
//   rf_wr_en, rf_wr_addr, wb_sel   writeback controls
//   mem_req, mem_we, mem_ack   memory handshake
//   ctrl_unsup                 pulse when an unsupported encoding is retired as NOP
// Configuration macro: IMM_SHIFT_EN enables LSHI decoding (see cr16_pkg).
module instr_ctrl_fsm
    import cr16_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RADDR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [3:0]       alu_op,
    output logic             set_znl,
    output logic [RADDR-1:0] rd_addr_a,
    output logic [RADDR-1:0] rd_addr_b,
    output logic             use_imm,
    output logic [WIDTH-1:0] imm_out,
    output logic             rf_wr_en,
    output logic [RADDR-1:0] rf_wr_addr,
    output logic [1:0]       wb_sel,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             ctrl_unsup
);

    state_e           state_q, state_d;
    logic             ready_en_q;
    logic [15:0]      ir_q;
    dec_t             dec;
    logic [WIDTH-1:0] imm_val;
    logic             accept;
    logic             dec_load;

    logic [RADDR-1:0] rd_addr_a_q, rd_addr_b_q, rf_wr_addr_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;
    logic [1:0]       wb_sel_q;
    logic [3:0]       alu_op_q;
    logic             set_znl_q;
    logic             mem_we_q;

    assign dec = decode_instr(ir_q[15:12], ir_q[7:4]);

    imm_ext #(
        .WIDTH (WIDTH)
    ) u_imm_ext (
        .imm8    (ir_q[7:0]),
        .mode    (dec.imm_mode),
        .imm_out (imm_val)
    );

    // ready_en_q keeps instr_ready low while in reset and until the first edge after release.
    assign accept   = ready_en_q && (state_q == StIdle) && instr_valid;
    assign dec_load = (state_q == StDecode) && dec.valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // IR and decoded-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q   <= 1'b0;
            ir_q         <= '0;
            rd_addr_a_q  <= '0;
            rd_addr_b_q  <= '0;
            rf_wr_addr_q <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
            wb_sel_q     <= '0;
            alu_op_q     <= '0;
            set_znl_q    <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                ir_q <= instr;
            end
            if (dec_load) begin
                rd_addr_a_q  <= ir_q[11:8];
                rd_addr_b_q  <= ir_q[3:0];
                rf_wr_addr_q <= ir_q[11:8];
                imm_q        <= imm_val;
                use_imm_q    <= dec.use_imm;
                wb_sel_q     <= dec.wb_sel;
                alu_op_q     <= dec.alu_op;
                set_znl_q    <= dec.set_znl;
                mem_we_q     <= dec.mem_we;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StDecode;
            end
            StDecode: begin
                if (!dec.valid) begin
                    state_d = StIdle;
                end else begin
                    unique case (dec.path)
                        PathExec: state_d = StExec;
                        PathMem:  state_d = StMem;
                        PathWb:   state_d = StWb;
                        default:  state_d = StIdle;
                    endcase
                end
            end
            StExec: state_d = set_znl_q ? StIdle : StWb; // compares have no writeback
            StMem: begin
                if (mem_ack) state_d = mem_we_q ? StIdle : StWb;
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = ready_en_q && (state_q == StIdle);
        alu_op      = '0;
        set_znl     = 1'b0;
        rf_wr_en    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ctrl_unsup  = 1'b0;
        unique case (state_q)
            StDecode: ctrl_unsup = !dec.valid;
            StExec: begin
                alu_op  = alu_op_q;
                set_znl = set_znl_q;
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = mem_we_q;
            end
            StWb:    rf_wr_en = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr_a  = rd_addr_a_q;
    assign rd_addr_b  = rd_addr_b_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign imm_out    = imm_q;
    assign use_imm    = use_imm_q;
    assign wb_sel     = wb_sel_q;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Directed self-checking bench for instr_ctrl_fsm. Expected values are hand-computed from
// the instruction encodings. Build with IMM_SHIFT_EN defined to exercise LSHI decoding.
module tb_instr_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic        set_znl;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        use_imm;
    logic [15:0] imm_out;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [1:0]  wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        ctrl_unsup;

    int checks = 0;
    int errors = 0;

    instr_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .set_znl     (set_znl),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .use_imm     (use_imm),
        .imm_out     (imm_out),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .wb_sel      (wb_sel),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .ctrl_unsup  (ctrl_unsup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE; returns in the DECODE cycle.
    task automatic issue(input logic [15:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        tick();
        tick();
        check("rst_ready", instr_ready, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rf_wr_en", rf_wr_en, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_imm_out", imm_out, 0);
        check("rst_unsup", ctrl_unsup, 0);
        rst_n = 1'b1;
        #1;
        check("release_ready_pre_edge", instr_ready, 0);
        tick();
        check("release_ready", instr_ready, 1);

        // ADD R3,R4 then reset while in EXEC
        issue(16'h0354);
        check("add_decode_ready", instr_ready, 0);
        tick();
        check("add_exec_alu_op", alu_op, 3);
        check("add_exec_rd_a", rd_addr_a, 3);
        check("add_exec_rd_b", rd_addr_b, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_alu_op", alu_op, 0);
        check("midrst_rd_a", rd_addr_a, 0);
        check("midrst_ready", instr_ready, 0);
        tick();
        check("midrst_no_wr", rf_wr_en, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready_after", instr_ready, 1);
        check("midrst_no_wr_after", rf_wr_en, 0);

        // ADDI R2,#-3: IDLE, DECODE, EXEC, WB
        issue(16'h52FD);
        check("addi_decode_alu_op", alu_op, 0);
        check("addi_decode_unsup", ctrl_unsup, 0);
        tick();
        check("addi_exec_alu_op", alu_op, 3);
        check("addi_exec_use_imm", use_imm, 1);
        check("addi_exec_imm", imm_out, 16'hFFFD);
        check("addi_exec_set_znl", set_znl, 0);
        check("addi_exec_wr_en", rf_wr_en, 0);
        tick();
        check("addi_wb_wr_en", rf_wr_en, 1);
        check("addi_wb_addr", rf_wr_addr, 2);
        check("addi_wb_sel", wb_sel, 0);
        check("addi_wb_alu_op", alu_op, 0);
        tick();
        check("addi_idle_ready", instr_ready, 1);
        check("addi_idle_wr_en", rf_wr_en, 0);

        // CMP R1,R2: 3 cycles, no writeback
        issue(16'h01B2);
        tick();
        check("cmp_exec_alu_op", alu_op, 4);
        check("cmp_exec_set_znl", set_znl, 1);
        check("cmp_exec_use_imm", use_imm, 0);
        check("cmp_exec_wr_en", rf_wr_en, 0);
        tick();
        check("cmp_idle_ready", instr_ready, 1);
        check("cmp_idle_set_znl", set_znl, 0);
        check("cmp_idle_wr_en", rf_wr_en, 0);

        // ANDI R4,#0x80: zero-extended
        issue(16'h1480);
        tick();
        check("andi_exec_alu_op", alu_op, 0);
        check("andi_exec_imm", imm_out, 16'h0080);
        check("andi_exec_use_imm", use_imm, 1);
        tick();
        check("andi_wb_wr_en", rf_wr_en, 1);
        tick();

        // LOAD R5,[R6] with three wait states; stray mem_ack in IDLE is ignored
        mem_ack = 1'b1;
        issue(16'h4506);
        mem_ack = 1'b0;
        check("load_decode_req", mem_req, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("load_mem_req", mem_req, 1);
            check("load_mem_we", mem_we, 0);
            check("load_rd_b", rd_addr_b, 6);
            if (i == 3) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        check("load_wb_req", mem_req, 0);
        check("load_wb_wr_en", rf_wr_en, 1);
        check("load_wb_sel", wb_sel, 1);
        check("load_wb_addr", rf_wr_addr, 5);
        tick();
        check("load_idle_ready", instr_ready, 1);

        // STOR R5,[R6] with zero wait states
        issue(16'h4546);
        tick();
        check("stor_mem_req", mem_req, 1);
        check("stor_mem_we", mem_we, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stor_idle_req", mem_req, 0);
        check("stor_idle_wr_en", rf_wr_en, 0);
        check("stor_idle_ready", instr_ready, 1);

        // LUI R7,#0xAB: DECODE -> WB
        issue(16'hF7AB);
        check("lui_decode_alu_op", alu_op, 0);
        tick();
        check("lui_wb_imm", imm_out, 16'hAB00);
        check("lui_wb_sel", wb_sel, 2);
        check("lui_wb_wr_en", rf_wr_en, 1);
        check("lui_wb_addr", rf_wr_addr, 7);
        check("lui_wb_alu_op", alu_op, 0);
        tick();

        // MOV R2,R9: writeback from RF port B
        issue(16'h02D9);
        tick();
        check("mov_wb_sel", wb_sel, 3);
        check("mov_wb_rd_b", rd_addr_b, 9);
        check("mov_wb_wr_en", rf_wr_en, 1);
        tick();

        // Bcond: unsupported, one-cycle pulse
        issue(16'hC123);
        check("bcond_unsup", ctrl_unsup, 1);
        tick();
        check("bcond_unsup_clear", ctrl_unsup, 0);
        check("bcond_ready", instr_ready, 1);
        check("bcond_wr_en", rf_wr_en, 0);

        // LSHI R1,#-2
        issue(16'h8112);
`ifdef IMM_SHIFT_EN
        check("lshi_decode_unsup", ctrl_unsup, 0);
        tick();
        check("lshi_exec_alu_op", alu_op, 6);
        check("lshi_exec_imm", imm_out, 16'hFFFE);
        check("lshi_exec_use_imm", use_imm, 1);
        tick();
        check("lshi_wb_wr_en", rf_wr_en, 1);
        tick();
`else
        check("lshi_unsup", ctrl_unsup, 1);
        check("lshi_alu_op", alu_op, 0);
        tick();
        check("lshi_unsup_clear", ctrl_unsup, 0);
        check("lshi_ready", instr_ready, 1);
        check("lshi_wr_en", rf_wr_en, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
